// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: synchronises the raw pins, decodes 11-bit frames and turns
// E0/F0-prefixed scancodes into make/break key events, queued in a show-ahead FIFO.
module ps2_key_event_rx #(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 50000,
    parameter int ERR_W       = 8
) (
    input  logic               CLOCK_50,
    input  logic               Resetn,
    input  logic               ps2_clk,
    input  logic               ps2_dat,
    output logic [7:0]         ev_code,
    output logic               ev_ext,
    output logic               ev_break,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow,
    output logic               frame_err,
    output logic [ERR_W-1:0]   err_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Bytes that carry no key information (BAT result, ACK, resend, Pause prefix, errors)
    function automatic logic is_swallowed(input logic [7:0] b);
        case (b)
            8'hE1, 8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    // ---- stage p0..p2: pin synchronisers and falling-edge detect ----
    logic clk_p0, clk_p1, clk_p2;
    logic dat_p0, dat_p1;
    logic fe, dat_s;

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            clk_p0 <= 1'b1;
            clk_p1 <= 1'b1;
            clk_p2 <= 1'b1;
            dat_p0 <= 1'b1;
            dat_p1 <= 1'b1;
        end else begin
            clk_p0 <= ps2_clk;
            clk_p1 <= clk_p0;
            clk_p2 <= clk_p1;
            dat_p0 <= ps2_dat;
            dat_p1 <= dat_p0;
        end
    end

    assign fe    = clk_p2 & ~clk_p1;
    assign dat_s = dat_p1;

    // ---- frame FSM: byte_ok / frame_err are registered one-cycle pulses ----
    state_t          state_q, state_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_ok_q, par_ok_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            byte_ok_q, byte_ok_d;
    logic            frame_err_q, frame_err_d;

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            par_ok_q    <= 1'b0;
            to_cnt_q    <= '0;
            byte_ok_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            par_ok_q    <= par_ok_d;
            to_cnt_q    <= to_cnt_d;
            byte_ok_q   <= byte_ok_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        shreg_q <= shreg_d;
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        par_ok_d    = par_ok_q;
        to_cnt_d    = to_cnt_q;
        byte_ok_d   = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == IDLE || fe) to_cnt_d = '0;
        else                       to_cnt_d = to_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (fe && !dat_s) begin
                    state_d  = DATA;
                    bitcnt_d = '0;
                end
            end
            DATA: begin
                if (fe) begin
                    shreg_d  = {dat_s, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fe) begin
                    par_ok_d = ^{shreg_q, dat_s};
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fe) begin
                    state_d = IDLE;
                    if (dat_s && par_ok_q) byte_ok_d   = 1'b1;
                    else                   frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled partial frame is abandoned so the next start bit is seen cleanly
        if (state_q != IDLE && !fe && to_cnt_q == TO_LIM) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            to_cnt_d    = '0;
        end
    end

    // ---- event decoder: prefixes fold into flags, key bytes emit events ----
    logic       ext_f, brk_f, ext_d, brk_d;
    logic       push;
    logic [9:0] push_data;

    always_comb begin
        ext_d = ext_f;
        brk_d = brk_f;
        push  = 1'b0;
        if (frame_err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_ok_q) begin
            if (shreg_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shreg_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (!is_swallowed(shreg_q)) begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    assign push_data = {ext_f, brk_f, shreg_q};

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
        end else begin
            ext_f <= ext_d;
            brk_f <= brk_d;
        end
    end

    // ---- event FIFO with registered head so outputs hold when empty ----
    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [9:0]         head_q, head_d;
    logic               pop, wr_en, drop, full;
    logic               ovf_q;
    logic [ERR_W-1:0]   err_cnt_q;

    assign full  = count_q[FIFO_AW];
    assign pop   = (count_q != '0) && ev_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // The new head is either already in memory or is the entry being written now
        if (count_d != '0) begin
            if (wr_en && rd_ptr_d == wr_ptr_q) head_d = push_data;
            else                               head_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) mem[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            head_q    <= '0;
            ovf_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            if (drop) ovf_q <= 1'b1;
            if (frame_err_q && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign ev_ext     = head_q[9];
    assign ev_break   = head_q[8];
    assign ev_code    = head_q[7:0];
    assign ev_valid   = (count_q != '0);
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign frame_err  = frame_err_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed bench for ps2_key_event_rx: bit-bangs PS/2 frames and checks the event stream.
module tb_ps2_key_event_rx;

    localparam int HALF = 20;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_dat  = 1'b1;
    logic       ev_ready = 1'b0;
    logic [7:0] ev_code;
    logic       ev_ext, ev_break, ev_valid, overflow, frame_err;
    logic [3:0] fifo_count;
    logic [7:0] err_count;

    int vectors    = 0;
    int miscompares = 0;
    int err_pulses = 0;

    ps2_key_event_rx dut (
        .CLOCK_50   (CLOCK_50),
        .Resetn     (Resetn),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_break   (ev_break),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .err_count  (err_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (Resetn && frame_err === 1'b1) err_pulses++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // Frame bits: start 0, data LSB first, odd parity (optionally inverted), stop
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_b,
                              input logic pop_sync, input int nbits);
        logic [10:0] f;
        f = {stop_b, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            repeat (HALF) @(negedge CLOCK_50);
            ps2_clk = 1'b0;
            if (i == 10 && pop_sync) begin
                repeat (3) @(negedge CLOCK_50);
                ev_ready = 1'b1;
                @(negedge CLOCK_50);
                ev_ready = 1'b0;
                repeat (HALF - 4) @(negedge CLOCK_50);
            end else begin
                repeat (HALF) @(negedge CLOCK_50);
            end
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge CLOCK_50);
    endtask

    task automatic pop_one();
        ev_ready = 1'b1;
        @(negedge CLOCK_50);
        ev_ready = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        vectors++;
        if ({ev_valid, fifo_count} !== 5'd0) begin
            $display("FAIL reset_valid_count: got %b/%0d required 0/0", ev_valid, fifo_count);
            miscompares++;
        end
        vectors++;
        if ({ev_ext, ev_break, ev_code} !== 10'd0) begin
            $display("FAIL reset_head: got %b%b %h required 00 00", ev_ext, ev_break, ev_code);
            miscompares++;
        end
        vectors++;
        if ({overflow, frame_err, err_count} !== 10'd0) begin
            $display("FAIL reset_status: got ovf=%b ferr=%b cnt=%0d required all 0", overflow, frame_err, err_count);
            miscompares++;
        end
        Resetn = 1'b1;
        repeat (5) @(negedge CLOCK_50);
    endtask

    task automatic test_make();
        int e0;
        e0 = err_pulses;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
        vectors++;
        if ({ev_valid, ev_ext, ev_break, ev_code, fifo_count} !== {3'b100, 8'h1C, 4'd1}) begin
            $display("FAIL make_1C: got v=%b e=%b b=%b code=%h cnt=%0d required 1 0 0 1c 1",
                     ev_valid, ev_ext, ev_break, ev_code, fifo_count);
            miscompares++;
        end
        pop_one();
        vectors++;
        if ({ev_valid, fifo_count} !== 5'd0 || err_pulses != e0) begin
            $display("FAIL make_pop: got v=%b cnt=%0d errs=%0d required 0 0 %0d",
                     ev_valid, fifo_count, err_pulses, e0);
            miscompares++;
        end
    endtask

    task automatic test_prefix();
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 11);
        vectors++;
        if (fifo_count !== 4'd0) begin
            $display("FAIL prefix_no_event: got cnt=%0d required 0", fifo_count);
            miscompares++;
        end
        send_frame(8'h75, 1'b0, 1'b1, 1'b0, 11);
        vectors++;
        if ({ev_ext, ev_break, ev_code, fifo_count} !== {2'b11, 8'h75, 4'd1}) begin
            $display("FAIL prefix_up_release: got e=%b b=%b code=%h cnt=%0d required 1 1 75 1",
                     ev_ext, ev_break, ev_code, fifo_count);
            miscompares++;
        end
        pop_one();
    endtask

    task automatic test_errors();
        int e0;
        e0 = err_pulses;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 11);
        vectors++;
        if (err_pulses - e0 != 2 || err_count !== 8'd2 || fifo_count !== 4'd0) begin
            $display("FAIL err_parity_stop: got pulses=%0d cnt=%0d fifo=%0d required 2 2 0",
                     err_pulses - e0, err_count, fifo_count);
            miscompares++;
        end
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
        vectors++;
        if ({ev_ext, ev_break, ev_code, fifo_count} !== {2'b00, 8'h1C, 4'd1}) begin
            $display("FAIL err_recover: got e=%b b=%b code=%h cnt=%0d required 0 0 1c 1",
                     ev_ext, ev_break, ev_code, fifo_count);
            miscompares++;
        end
        pop_one();
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_pulses;
        send_frame(8'h05, 1'b0, 1'b1, 1'b0, 4);
        repeat (49000) @(negedge CLOCK_50);
        vectors++;
        if (err_pulses != e0) begin
            $display("FAIL timeout_early: got pulses=%0d required 0", err_pulses - e0);
            miscompares++;
        end
        repeat (2000) @(negedge CLOCK_50);
        vectors++;
        if (err_pulses - e0 != 1 || err_count !== 8'd3) begin
            $display("FAIL timeout_fire: got pulses=%0d cnt=%0d required 1 3", err_pulses - e0, err_count);
            miscompares++;
        end
        send_frame(8'h29, 1'b0, 1'b1, 1'b0, 11);
        vectors++;
        if ({ev_ext, ev_break, ev_code, fifo_count} !== {2'b00, 8'h29, 4'd1}) begin
            $display("FAIL timeout_recover: got e=%b b=%b code=%h cnt=%0d required 0 0 29 1",
                     ev_ext, ev_break, ev_code, fifo_count);
            miscompares++;
        end
        pop_one();
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0, 11);
        vectors++;
        if ({fifo_count, overflow, ev_code} !== {4'd8, 1'b1, 8'h01}) begin
            $display("FAIL ovf_full: got cnt=%0d ovf=%b head=%h required 8 1 01", fifo_count, overflow, ev_code);
            miscompares++;
        end
        send_frame(8'h0A, 1'b0, 1'b1, 1'b1, 11);
        vectors++;
        if ({fifo_count, ev_code} !== {4'd8, 8'h02}) begin
            $display("FAIL ovf_push_pop: got cnt=%0d head=%h required 8 02", fifo_count, ev_code);
            miscompares++;
        end
        for (int k = 2; k <= 9; k++) begin
            exp = (k == 9) ? 8'h0A : 8'(k);
            vectors++;
            if (ev_valid !== 1'b1 || ev_code !== exp) begin
                $display("FAIL ovf_order: got v=%b code=%h required 1 %h", ev_valid, ev_code, exp);
                miscompares++;
            end
            pop_one();
        end
        vectors++;
        if ({ev_valid, overflow, ev_code} !== {2'b01, 8'h0A}) begin
            $display("FAIL ovf_drain: got v=%b ovf=%b code=%h required 0 1 0a", ev_valid, overflow, ev_code);
            miscompares++;
        end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 11);
        send_frame(8'h12, 1'b0, 1'b1, 1'b0, 11);
        send_frame(8'h13, 1'b0, 1'b1, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 11);
        send_frame(8'h3F, 1'b0, 1'b1, 1'b0, 6);
        vectors++;
        if (fifo_count !== 4'd3) begin
            $display("FAIL mid_queued: got cnt=%0d required 3", fifo_count);
            miscompares++;
        end
        Resetn = 1'b0;
        @(negedge CLOCK_50);
        Resetn = 1'b1;
        vectors++;
        if ({ev_valid, ev_ext, ev_break, ev_code, fifo_count, overflow, frame_err, err_count} !== 26'd0) begin
            $display("FAIL mid_reset: got v=%b e=%b b=%b code=%h cnt=%0d ovf=%b ferr=%b ec=%0d required all 0",
                     ev_valid, ev_ext, ev_break, ev_code, fifo_count, overflow, frame_err, err_count);
            miscompares++;
        end
        repeat (5) @(negedge CLOCK_50);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
        vectors++;
        if ({ev_ext, ev_break, ev_code, fifo_count, err_count} !== {2'b00, 8'h1C, 4'd1, 8'd0}) begin
            $display("FAIL mid_recover: got e=%b b=%b code=%h cnt=%0d ec=%0d required 0 0 1c 1 0",
                     ev_ext, ev_break, ev_code, fifo_count, err_count);
            miscompares++;
        end
        pop_one();
    endtask

    initial begin
        @(negedge CLOCK_50);
        test_reset();
        test_make();
        test_prefix();
        test_errors();
        test_timeout();
        test_overflow();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
